axi_slv_mem: RTL
================

AXI_SLV_MEM -- requirements
Module: axi_slv_mem

Interface
REQ-001 Parameter ID_WIDTH, default 4, AXI ID width on all channels.
REQ-002 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter DATA_WIDTH, default 32, data bus width; legal values are 32, 64 and 128.
REQ-004 Parameter MEM_DEPTH, default 1024, number of DATA_WIDTH-bit words; must be a power of 2.
REQ-005 ACLK  in  1  single clock; all logic is on the rising edge.
REQ-006 ARESET  in  1  reset; synchronous, active-high.
REQ-007 AW channel (in unless noted): AWID[ID_WIDTH], AWADDR[ADDR_WIDTH], AWLEN[8], AWSIZE[3], AWBURST[2], AWPROT[3], AWVALID[1]; AWREADY[1] out.
REQ-008 W channel (in unless noted): WDATA[DATA_WIDTH], WSTRB[DATA_WIDTH/8], WLAST[1], WVALID[1]; WREADY[1] out.
REQ-009 B channel (out unless noted): BID[ID_WIDTH], BRESP[2], BVALID[1]; BREADY[1] in.
REQ-010 AR channel (in unless noted): ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID, with widths as on AW; ARREADY[1] out.
REQ-011 R channel (out unless noted): RID[ID_WIDTH], RDATA[DATA_WIDTH], RRESP[2], RLAST[1], RVALID[1]; RREADY[1] in.

Function
REQ-012 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP; AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA, BVALID=1 only in W_RESP.
REQ-013 On an AW handshake the block SHALL latch ID, ADDR, LEN, SIZE and BURST, clear the beat counter, and enter W_DATA on the next cycle.
REQ-014 On each W handshake the block SHALL write the lanes enabled by WSTRB into word (addr >> log2(DATA_WIDTH/8)) mod MEM_DEPTH; lanes with a 0 strobe SHALL be left unchanged.
REQ-015 After each beat the address SHALL update by burst type:
  - FIXED (00): unchanged.
  - INCR (01): addr + (1<<SIZE).
  - WRAP (10): per REQ-033.
REQ-016 The beat whose count equals the latched LEN SHALL be the last beat; the block SHALL then enter W_RESP with BID equal to the latched ID.
REQ-017 BRESP SHALL be 2'b10 (SLVERR) if any of the following holds; otherwise BRESP SHALL be 2'b00:
  - WLAST was 1 on a non-last beat, or 0 on the last beat;
  - SIZE > log2(DATA_WIDTH/8);
  - BURST is 2'b11;
  - the burst is an illegal WRAP.
REQ-018 For the SIZE, BURST and illegal-WRAP error cases the beats SHALL be accepted but memory SHALL NOT be written; for the WLAST-mismatch case the beats SHALL still be written.
REQ-019 The B handshake SHALL return the write FSM to W_IDLE; BVALID and BID/BRESP SHALL hold stable while BREADY=0.
REQ-020 The read FSM SHALL have states R_IDLE and R_DATA; ARREADY=1 only in R_IDLE.
REQ-021 RVALID SHALL assert exactly one cycle after the AR handshake, with RDATA registered from the first word.
REQ-022 Each R handshake SHALL advance the address per REQ-015 and present the next beat in the following cycle.
REQ-023 RDATA, RID, RRESP and RLAST SHALL hold stable while RVALID=1 and RREADY=0.
REQ-024 RLAST SHALL be 1 only on beat LEN; the R handshake on the last beat SHALL return the read FSM to R_IDLE with RVALID=0 in the next cycle.
REQ-025 RRESP SHALL apply the error conditions of REQ-017 except WLAST; on an error beat RDATA SHALL be 0, and the full LEN+1 beats SHALL still be returned.
REQ-026 The read and write FSMs SHALL run independently and concurrently.
REQ-027 If a read fetch and a write hit the same word in the same cycle, the read SHALL return the pre-write data.
REQ-028 Address arithmetic SHALL be ADDR_WIDTH wide, and INCR SHALL wrap silently at 2^ADDR_WIDTH.
REQ-029 Memory indexing SHALL use the word address modulo MEM_DEPTH, with no out-of-range error.

Reset
REQ-030 While ARESET=1 the block SHALL drive AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST to 0, and BID, BRESP, RID, RRESP and RDATA to 0.
REQ-031 AWREADY and ARREADY SHALL be 1 in the first cycle after ARESET deasserts.
REQ-032 An assertion of ARESET mid-burst SHALL abort both FSMs to their IDLE states with no B or R completion; memory contents SHALL be retained and never cleared.

Configuration
REQ-033 With macro AXI_SLV_MEM_WRAP_EN defined, WRAP bursts SHALL be supported as follows:
  - LEN must be 1, 3, 7 or 15, and ADDR must be aligned to 1<<SIZE; otherwise the burst is an illegal WRAP.
  - The wrap boundary SHALL be (LEN+1)<<SIZE.
  - The address SHALL increment as for INCR and wrap to the lower boundary on crossing the upper one.
REQ-034 Without AXI_SLV_MEM_WRAP_EN, every BURST=2'b10 SHALL be an illegal WRAP (SLVERR), and no wrap logic SHALL be synthesised.

Verification
REQ-035 Single write then read: AW addr 0x10, LEN 0, SIZE 2, INCR; WDATA 0xDEADBEEF, WSTRB 0xF -> BRESP 00, BID matches AWID; then AR addr 0x10 -> RDATA 0xDEADBEEF, RLAST=1, RRESP 00.
REQ-036 INCR burst with backpressure: write LEN 3 from 0x0 with data 1,2,3,4, then read LEN 3 from 0x0 with RREADY toggling every cycle -> RDATA 1,2,3,4 in order, held stable while stalled, RLAST only on beat 4.
REQ-037 Strobe and WLAST error: write 0xFFFFFFFF to 0x20, then write 0x12345678 with WSTRB 0x3 -> word reads 0xFFFF5678; a LEN 1 write with WLAST=1 on beat 0 -> BRESP 10.
REQ-038 WRAP burst: with AXI_SLV_MEM_WRAP_EN, LEN 3, SIZE 2, addr 0x08 -> beats hit 0x08, 0x0C, 0x00, 0x04, RRESP 00; without the macro -> RRESP 10 on all 4 beats and RDATA 0.
REQ-039 Reset mid-burst: assert ARESET during beat 2 of a LEN 7 write -> no BVALID; one cycle after reset release AWREADY=1, and beats 0-1 remain readable.

Source files
------------

// File: rtl/axi_slv_mem_if.sv
// AXI4 slave-memory bus bundle: AW, W, B, AR and R channels.
// The master modport drives requests; the slave modport drives responses.
interface axi_slv_mem_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;

    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;

    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;

    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_slv_mem.sv
// AXI4 slave backed by a MEM_DEPTH x DATA_WIDTH memory with independent
// read and write FSMs. WRAP bursts are supported only when the macro
// AXI_SLV_MEM_WRAP_EN is defined; otherwise every WRAP burst returns SLVERR.
module axi_slv_mem #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic         ACLK,
    input  logic         ARESET,
    axi_slv_mem_if.slave s_axi
);
    localparam int          STRB_W     = DATA_WIDTH / 8;
    localparam int          LOG2_BYTES = $clog2(STRB_W);
    localparam int          IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [2:0]  MAX_SIZE   = 3'(LOG2_BYTES);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Address of the beat following 'addr' for the given burst type.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] incr;
`ifdef AXI_SLV_MEM_WRAP_EN
        logic [ADDR_WIDTH-1:0] mask;
`else
        logic                  unused_len;
`endif
        step = ADDR_WIDTH'(1) << size;
        incr = addr + step;
`ifdef AXI_SLV_MEM_WRAP_EN
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
`else
        unused_len = ^len;
`endif
        case (burst)
            2'b01:   next_addr = incr;
`ifdef AXI_SLV_MEM_WRAP_EN
            2'b10:   next_addr = (addr & ~mask) | (incr & mask);
`endif
            default: next_addr = addr;
        endcase
    endfunction

    // Burst-level error: oversize beat, reserved burst type or illegal WRAP.
    function automatic logic burst_err(
        input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst);
        logic err;
`ifndef AXI_SLV_MEM_WRAP_EN
        logic unused_wrap;
`endif
        err = (size > MAX_SIZE) || (burst == 2'b11);
`ifdef AXI_SLV_MEM_WRAP_EN
        if (burst == 2'b10) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
            if ((addr & ((ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1))) != '0) err = 1'b1;
        end
`else
        unused_wrap = ^{addr, len};
        if (burst == 2'b10) err = 1'b1;
`endif
        burst_err = err;
    endfunction

    // Word index: byte address to word address, modulo MEM_DEPTH.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        word_idx = IDX_W'(addr >> LOG2_BYTES);
    endfunction

    logic unused_prot;
    assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

    // ---------------- write side ----------------
    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]            aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d, bresp_q, bresp_d;
    logic                  w_bad_q, w_bad_d, w_wlerr_q, w_wlerr_d;
    logic                  w_last, mem_we;
    logic [IDX_W-1:0]      mem_widx;

    // Write FSM next state, address sequencing and memory write enables.
    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_bad_d    = w_bad_q;
        w_wlerr_d  = w_wlerr_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        mem_widx   = word_idx(aw_addr_q);
        w_last     = (w_cnt_q == aw_len_q);
        unique case (w_state_q)
            W_IDLE: if (s_axi.AWVALID) begin
                aw_id_d    = s_axi.AWID;
                aw_addr_d  = s_axi.AWADDR;
                aw_len_d   = s_axi.AWLEN;
                aw_size_d  = s_axi.AWSIZE;
                aw_burst_d = s_axi.AWBURST;
                w_cnt_d    = 8'd0;
                w_bad_d    = burst_err(s_axi.AWADDR, s_axi.AWLEN, s_axi.AWSIZE, s_axi.AWBURST);
                w_wlerr_d  = 1'b0;
                w_state_d  = W_DATA;
            end
            W_DATA: if (s_axi.WVALID) begin
                // Burst-level errors suppress the write; a WLAST mismatch does not.
                mem_we = !w_bad_q && !ARESET;
                if (s_axi.WLAST != w_last) w_wlerr_d = 1'b1;
                if (w_last) begin
                    w_state_d = W_RESP;
                    bresp_d   = (w_bad_q || w_wlerr_q || (s_axi.WLAST != w_last)) ? RESP_SLV : RESP_OKAY;
                end else begin
                    w_cnt_d   = w_cnt_q + 8'd1;
                    aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                end
            end
            W_RESP: if (s_axi.BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write-side state registers; reset aborts any burst in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_bad_q    <= 1'b0;
            w_wlerr_q  <= 1'b0;
            bresp_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_bad_q    <= w_bad_d;
            w_wlerr_q  <= w_wlerr_d;
            bresp_q    <= bresp_d;
        end
    end

    // Byte-lane memory write; contents are never cleared by reset.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.WSTRB[b]) mem[mem_widx][b*8 +: 8] <= s_axi.WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read side ----------------
    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_nxt;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]            r_size_q, r_size_d;
    logic [1:0]            r_burst_q, r_burst_d, rresp_q, rresp_d;
    logic                  r_bad_q, r_bad_d, rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Read FSM: fetch the first word on AR, the next word on each R handshake.
    // The array is read before this edge's write lands, so a same-cycle
    // collision returns the pre-write data.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_bad_d   = r_bad_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        r_nxt     = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
        unique case (r_state_q)
            R_IDLE: if (s_axi.ARVALID) begin
                rid_d     = s_axi.ARID;
                r_addr_d  = s_axi.ARADDR;
                r_len_d   = s_axi.ARLEN;
                r_size_d  = s_axi.ARSIZE;
                r_burst_d = s_axi.ARBURST;
                r_cnt_d   = 8'd0;
                r_bad_d   = burst_err(s_axi.ARADDR, s_axi.ARLEN, s_axi.ARSIZE, s_axi.ARBURST);
                rresp_d   = r_bad_d ? RESP_SLV : RESP_OKAY;
                rlast_d   = (s_axi.ARLEN == 8'd0);
                rdata_d   = r_bad_d ? '0 : mem[word_idx(s_axi.ARADDR)];
                r_state_d = R_DATA;
            end
            R_DATA: if (s_axi.RREADY) begin
                if (rlast_q) begin
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    r_addr_d = r_nxt;
                    r_cnt_d  = r_cnt_q + 8'd1;
                    rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
                    rdata_d  = r_bad_q ? '0 : mem[word_idx(r_nxt)];
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read-side state registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_bad_q   <= 1'b0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_bad_q   <= r_bad_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign s_axi.AWREADY = !ARESET && (w_state_q == W_IDLE);
    assign s_axi.WREADY  = !ARESET && (w_state_q == W_DATA);
    assign s_axi.BVALID  = !ARESET && (w_state_q == W_RESP);
    assign s_axi.BID     = aw_id_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = !ARESET && (r_state_q == R_IDLE);
    assign s_axi.RVALID  = !ARESET && (r_state_q == R_DATA);
    assign s_axi.RID     = rid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
    assign s_axi.RLAST   = rlast_q;
endmodule
